// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-through cache controller with burst line refill
// Read misses refill a whole line from word-wide memory; stores always go straight to memory.

module dm_cache_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LINES  = 32,
  parameter int WORDS  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_rd_en,
  input  logic              cpu_wr_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, REFILL, WDONE} state_t;

  state_t            state;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*WORDS];
  logic [OFF_W-1:0]  beat;
  logic              refilled;

  logic [OFF_W-1:0]  addr_off;
  logic [IDX_W-1:0]  addr_idx;
  logic [TAG_W-1:0]  addr_tag;
  logic [OFF_W-1:0]  beat_nxt;
  logic              last_beat;
  logic              hit;
  logic              rd_hit;

  assign addr_off  = cpu_addr[OFF_W-1:0];
  assign addr_idx  = cpu_addr[OFF_W +: IDX_W];
  assign addr_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
  assign beat_nxt  = beat + OFF_W'(1);
  assign last_beat = (beat == LAST_BEAT);

  assign hit    = valid[addr_idx] && (tag_mem[addr_idx] == addr_tag);
  assign rd_hit = (state == IDLE) && !flush && !cpu_wr_en && cpu_rd_en && hit;

  assign cpu_rdata = rd_hit ? data_mem[{addr_idx, addr_off}] : '0;

  always_comb begin
    cpu_stall = 1'b0;
    case (state)
      IDLE:          cpu_stall = flush | cpu_wr_en | (cpu_rd_en & ~hit);
      WRITE, REFILL: cpu_stall = 1'b1;
      default:       cpu_stall = 1'b0;
    endcase
  end

  // Line storage carries no reset; the valid bits alone decide what is usable.
  always_ff @(posedge clk) begin
    if (state == WRITE && mem_ready && hit) begin
      data_mem[{addr_idx, addr_off}] <= cpu_wdata;
    end
    if (state == REFILL && mem_ready) begin
      data_mem[{addr_idx, beat}] <= mem_rdata;
      if (last_beat) begin
        tag_mem[addr_idx] <= addr_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      valid     <= '0;
      beat      <= '0;
      refilled  <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
          end else if (cpu_wr_en) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            state     <= WRITE;
          end else if (cpu_rd_en) begin
            if (hit) begin
              // The first hit after a refill is the held miss retiring, not a new hit.
              if (!refilled && hit_cnt != CNT_MAX) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
              end
              refilled <= 1'b0;
            end else begin
              if (miss_cnt != CNT_MAX) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
              end
              // Drop the victim line now so a half-overwritten line is never valid.
              valid[addr_idx] <= 1'b0;
              beat     <= '0;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {addr_tag, addr_idx, {OFF_W{1'b0}}};
              state    <= REFILL;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= WDONE;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            beat <= beat_nxt;
            if (last_beat) begin
              valid[addr_idx] <= 1'b1;
              refilled        <= 1'b1;
              mem_req         <= 1'b0;
              state           <= IDLE;
            end else begin
              mem_addr <= {addr_tag, addr_idx, beat_nxt};
            end
          end
        end
        WDONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - randomized self-checking bench for dm_cache_ctrl
// Expected data comes from a golden memory image; hit/miss from a tag/valid model of the line array.

module tb_dm_cache_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LINES  = 32;
  localparam int WORDS  = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cpu_rd_en, cpu_wr_en, flush;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_stall;
  logic              mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dm_cache_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .WORDS(WORDS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem_array [1 << ADDR_W];
  logic [DATA_W-1:0] gm        [1 << ADDR_W];
  bit                m_valid   [LINES];
  int                m_tag     [LINES];
  int                exp_hits, exp_misses;

  int                ready_lat = 0;
  int                wcnt = 0;
  logic [ADDR_W-1:0] log_addr [$];
  logic              log_we   [$];
  logic [DATA_W-1:0] log_data [$];
  bit                hold_pending = 0;
  logic [ADDR_W-1:0] hold_addr;
  logic              hold_we;

  // Memory responder: mem_ready after ready_lat waiting cycles per beat.
  always @(negedge clk) begin
    if (mem_req !== 1'b1) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      wcnt = 0;
    end else if (wcnt >= ready_lat) begin
      mem_ready = 1'b1;
      mem_rdata = mem_array[mem_addr];
      wcnt = 0;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      wcnt++;
    end
  end

  always @(posedge clk) begin
    if (reset_n === 1'b1 && mem_req === 1'b1) begin
      if (hold_pending) begin
        n_checks++;
        if (mem_addr !== hold_addr || mem_we !== hold_we) begin
          n_fail++;
          $display("FAIL mem_hold addr/we changed before accept: got %h/%b required %h/%b",
                   mem_addr, mem_we, hold_addr, hold_we);
        end
      end
      if (mem_ready) begin
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_data.push_back(mem_wdata);
        if (mem_we) mem_array[mem_addr] = mem_wdata;
        hold_pending = 0;
      end else begin
        hold_pending = 1;
        hold_addr = mem_addr;
        hold_we = mem_we;
      end
    end else begin
      hold_pending = 0;
    end
  end

  function automatic bit model_hit(input logic [ADDR_W-1:0] a);
    int idx = (int'(a) / WORDS) % LINES;
    int tag = int'(a) / (WORDS * LINES);
    return m_valid[idx] && (m_tag[idx] == tag);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_data.delete();
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int lat);
    bit eh;
    bit ok;
    int stalls;
    int exp_stalls;
    int base;
    eh = model_hit(a);
    stalls = 0;
    base = (int'(a) / WORDS) * WORDS;
    exp_stalls = eh ? 0 : 1 + WORDS * (lat + 1);
    @(posedge clk); #1;
    ready_lat = lat;
    clear_log();
    cpu_wr_en = 0; flush = 0; cpu_rd_en = 1; cpu_addr = a;
    @(negedge clk);
    while (cpu_stall !== 1'b0 && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    n_checks++;
    if (cpu_rdata !== gm[a]) begin
      n_fail++;
      $display("FAIL read_data addr=%h got %h required %h", a, cpu_rdata, gm[a]);
    end
    n_checks++;
    if (stalls != exp_stalls) begin
      n_fail++;
      $display("FAIL read_stall addr=%h stall cycles %0d required %0d", a, stalls, exp_stalls);
    end
    ok = eh ? (log_addr.size() == 0) : (log_addr.size() == WORDS);
    if (ok && !eh) begin
      for (int i = 0; i < WORDS; i++)
        if (log_addr[i] !== ADDR_W'(base + i) || log_we[i] !== 1'b0) ok = 0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL read_traffic addr=%h beats %0d required %0d reads from %h",
               a, log_addr.size(), eh ? 0 : WORDS, ADDR_W'(base));
    end
    if (eh) begin
      exp_hits = (exp_hits < CNT_SAT) ? exp_hits + 1 : CNT_SAT;
    end else begin
      exp_misses = (exp_misses < CNT_SAT) ? exp_misses + 1 : CNT_SAT;
      m_valid[(int'(a) / WORDS) % LINES] = 1;
      m_tag[(int'(a) / WORDS) % LINES] = int'(a) / (WORDS * LINES);
    end
    @(posedge clk); #1;
    cpu_rd_en = 0;
    @(negedge clk);
    n_checks++;
    if (hit_cnt !== CNT_W'(exp_hits)) begin
      n_fail++;
      $display("FAIL hit_cnt after read %h got %0d required %0d", a, hit_cnt, exp_hits);
    end
    n_checks++;
    if (miss_cnt !== CNT_W'(exp_misses)) begin
      n_fail++;
      $display("FAIL miss_cnt after read %h got %0d required %0d", a, miss_cnt, exp_misses);
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int lat, input bit both);
    bit bad;
    int stalls;
    bad = 0;
    stalls = 0;
    @(posedge clk); #1;
    ready_lat = lat;
    clear_log();
    flush = 0; cpu_wr_en = 1; cpu_rd_en = both; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    while (cpu_stall !== 1'b0 && stalls < 200) begin
      if (stalls == 0) begin
        if (mem_req !== 1'b0) bad = 1;
      end else if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== d) begin
        bad = 1;
      end
      stalls++;
      @(negedge clk);
    end
    n_checks++;
    if (bad || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL write_bus addr=%h data=%h bus held wrong (req=%b we=%b addr=%h wdata=%h at end)",
               a, d, mem_req, mem_we, mem_addr, mem_wdata);
    end
    n_checks++;
    if (stalls != lat + 2) begin
      n_fail++;
      $display("FAIL write_stall addr=%h stall cycles %0d required %0d", a, stalls, lat + 2);
    end
    n_checks++;
    if (log_addr.size() != 1 || log_addr[0] !== a || log_we[0] !== 1'b1 || log_data[0] !== d) begin
      n_fail++;
      $display("FAIL write_traffic addr=%h beats %0d required one write of %h", a, log_addr.size(), d);
    end
    gm[a] = d;
    @(posedge clk); #1;
    cpu_wr_en = 0; cpu_rd_en = 0;
    @(negedge clk);
    n_checks++;
    if (hit_cnt !== CNT_W'(exp_hits) || miss_cnt !== CNT_W'(exp_misses)) begin
      n_fail++;
      $display("FAIL write_counters got %0d/%0d required %0d/%0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    cpu_rd_en = 0; cpu_wr_en = 0; flush = 1;
    @(negedge clk);
    n_checks++;
    if (cpu_stall !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall stall=%b req=%b required 1/0", cpu_stall, mem_req);
    end
    @(posedge clk); #1;
    flush = 0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 0;
    cpu_rd_en = 0; cpu_wr_en = 0; flush = 0;
    model_reset();
    @(negedge clk); #1;
    reset_n = 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem got req=%b we=%b addr=%h wdata=%h required all zero",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    n_checks++;
    if (cpu_stall !== 1'b0 || cpu_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_cpu got stall=%b rdata=%h required 0/0", cpu_stall, cpu_rdata);
    end
    n_checks++;
    if (hit_cnt !== '0 || miss_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_counters got %0d/%0d required 0/0", hit_cnt, miss_cnt);
    end
    #1 reset_n = 1;
  endtask

  task automatic test_cold_read();
    do_read(10'h085, 0);
  endtask

  task automatic test_hit_read();
    do_read(10'h086, 0);
  endtask

  task automatic test_write_hit();
    do_write(10'h085, 32'h55, 3, 0);
    do_read(10'h085, 0);
  endtask

  task automatic test_write_miss();
    do_write(10'h185, 32'hDEAD_BEEF, 1, 0);
    do_read(10'h085, 0);
    do_read(10'h185, 2);
  endtask

  task automatic test_flush();
    do_flush();
    do_read(10'h085, 0);
  endtask

  task automatic test_both_enables();
    do_write(10'h086, 32'h1234_5678, 1, 1);
    do_read(10'h086, 0);
  endtask

  task automatic test_reset_mid_burst();
    int waited;
    waited = 0;
    do_flush();
    @(posedge clk); #1;
    ready_lat = 0;
    clear_log();
    cpu_rd_en = 1; cpu_addr = 10'h085;
    while (log_addr.size() < 2 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (log_addr.size() < 2) begin
      n_fail++;
      $display("FAIL midburst_start beats %0d required 2", log_addr.size());
    end
    #2 reset_n = 0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_addr !== '0 || hit_cnt !== '0 || miss_cnt !== '0) begin
      n_fail++;
      $display("FAIL midburst_reset got req=%b addr=%h cnt=%0d/%0d required 0/000/0/0",
               mem_req, mem_addr, hit_cnt, miss_cnt);
    end
    cpu_rd_en = 0;
    model_reset();
    @(negedge clk); #1;
    reset_n = 1;
    do_read(10'h085, 0);
  endtask

  task automatic test_random();
    int op;
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < 250; k++) begin
      op = $urandom_range(0, 99);
      a = ADDR_W'($urandom_range(0, 3) * 128 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      if (op < 55)      do_read(a, $urandom_range(0, 3));
      else if (op < 93) do_write(a, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      else              do_flush();
    end
  endtask

  task automatic test_counter_saturation();
    apply_reset();
    for (int i = 0; i < 21; i++) do_read(ADDR_W'(10'h2a0 + (i % WORDS)), 0);
    n_checks++;
    if (hit_cnt !== CNT_W'(CNT_SAT)) begin
      n_fail++;
      $display("FAIL hit_saturate got %0d required %0d", hit_cnt, CNT_SAT);
    end
    for (int i = 0; i < 17; i++) begin
      do_flush();
      do_read(ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)), 0);
    end
    n_checks++;
    if (miss_cnt !== CNT_W'(CNT_SAT)) begin
      n_fail++;
      $display("FAIL miss_saturate got %0d required %0d", miss_cnt, CNT_SAT);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] v;
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      v = $urandom;
      mem_array[a] = v;
      gm[a] = v;
    end
    for (int i = 0; i < 4; i++) begin
      mem_array[10'h084 + i] = DATA_W'(32'hA0 + i);
      gm[10'h084 + i] = DATA_W'(32'hA0 + i);
    end
    reset_n = 0;
    cpu_rd_en = 0; cpu_wr_en = 0; flush = 0;
    cpu_addr = '0; cpu_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    model_reset();

    test_reset();
    test_cold_read();
    test_hit_read();
    test_write_hit();
    test_write_miss();
    test_flush();
    test_both_enables();
    test_reset_mid_burst();
    test_random();
    test_counter_saturation();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
